// File: rtl/abuf_drain.sv
// abuf_drain: walks the accum-buffer read port over a finished tile and streams the
// words out on valid/ready with credit flow control. Optional `DRAIN_RELU_EN adds output ReLU.

package global_param;
  localparam int BATCH = 1;
  localparam int RES_W = 32;
endpackage

module abuf_drain
  import global_param::*;
#(
  parameter  int PE_NUM     = 32,
  parameter  int BUF_DEPTH  = 256,
  parameter  int RD_LAT     = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int GRP_NUM    = PE_NUM / 4,
  localparam int GSEL_W     = $clog2(GRP_NUM),
  localparam int GCNT_W     = GSEL_W + 1,
  localparam int ADDR_W     = $clog2(BUF_DEPTH),
  localparam int WORD_W     = 4 * BATCH * RES_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GCNT_W-1:0] grp_cnt,
  input  logic [ADDR_W-1:0] addr_cnt,
  output logic              busy,
  output logic              done,
  output logic [GSEL_W-1:0] rd_sel,
  output logic [ADDR_W-1:0] abuf_rd_addr,
  input  logic [WORD_W-1:0] abuf_rd_data,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t              state_r;
  logic [GSEL_W-1:0]   rd_sel_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [GSEL_W-1:0]   grp_last_r;
  logic [ADDR_W-1:0]   addr_last_r;
  logic                busy_r;
  logic                done_r;
  logic [RD_LAT:0]     tag_vld_r;
  logic [RD_LAT:0]     tag_last_r;

  logic [WORD_W-1:0]   fifo_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    fifo_cnt_r;
  logic                out_valid_r;

  logic                push_s;
  logic                pop_s;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [CRD_W-1:0]    inflight_s;
  logic                credit_ok_s;
  logic [GSEL_W-1:0]   nxt_sel_s;
  logic [ADDR_W-1:0]   nxt_addr_s;
  logic                nxt_is_last_s;
  logic                issue_s;
  logic                issue_last_s;

  // Tag pipe: stage RD_LAT is the cycle in which abuf_rd_data matches the issued address.
  assign push_s    = tag_vld_r[RD_LAT];
  assign pop_s     = out_valid_r & out_ready;
  assign cnt_nxt_s = fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);

  // Reads still in flight toward the FIFO.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i <= RD_LAT; i++) begin
      inflight_s = inflight_s + CRD_W'(tag_vld_r[i]);
    end
  end

  // A popping word frees its slot this cycle, which keeps 1 word/clk sustainable.
  assign credit_ok_s = (inflight_s + CRD_W'(fifo_cnt_r)) < (CRD_W'(FIFO_DEPTH) + CRD_W'(pop_s));

  // Next read index, group-major / address-minor.
  always_comb begin
    nxt_sel_s  = rd_sel_r;
    nxt_addr_s = addr_r + ADDR_W'(1);
    if (addr_r == addr_last_r) begin
      nxt_sel_s  = rd_sel_r + GSEL_W'(1);
      nxt_addr_s = '0;
    end else begin
      nxt_sel_s  = rd_sel_r;
    end
    nxt_is_last_s = (nxt_sel_s == grp_last_r) && (nxt_addr_s == addr_last_r);
  end

  // Issue decision: first read goes out on the accepted start edge.
  always_comb begin
    issue_s      = 1'b0;
    issue_last_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (grp_cnt != '0)) begin
          issue_s      = 1'b1;
          issue_last_s = (grp_cnt == GCNT_W'(1)) && (addr_cnt == '0);
        end else begin
          issue_s      = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (credit_ok_s) begin
          issue_s      = 1'b1;
          issue_last_s = nxt_is_last_s;
        end else begin
          issue_s      = 1'b0;
        end
      end
      default: begin
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
      end
    endcase
  end

  // Control FSM with read-port and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      rd_sel_r    <= '0;
      addr_r      <= '0;
      grp_last_r  <= '0;
      addr_last_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            busy_r <= 1'b1;
            if (grp_cnt != '0) begin
              rd_sel_r    <= '0;
              addr_r      <= '0;
              grp_last_r  <= GSEL_W'(grp_cnt - GCNT_W'(1));
              addr_last_r <= addr_cnt;
              state_r     <= issue_last_s ? ST_FLUSH : ST_ISSUE;
            end else begin
              done_r  <= 1'b1;
              state_r <= ST_FIN;
            end
          end
        end
        ST_ISSUE: begin
          if (issue_s) begin
            rd_sel_r <= nxt_sel_s;
            addr_r   <= nxt_addr_s;
            if (issue_last_s) begin
              state_r <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if ((cnt_nxt_s == CNT_W'(0)) && (tag_vld_r[RD_LAT-1:0] == '0)) begin
            done_r  <= 1'b1;
            state_r <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Latency-matching tag pipe carrying the valid and last markers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_r  <= '0;
      tag_last_r <= '0;
    end else begin
      tag_vld_r  <= {tag_vld_r[RD_LAT-1:0], issue_s};
      tag_last_r <= {tag_last_r[RD_LAT-1:0], issue_s & issue_last_s};
    end
  end

  // Return skid FIFO; storage is cleared so outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= '0;
      end
      fifo_last_r <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      fifo_cnt_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= abuf_rd_data;
        fifo_last_r[wr_ptr_r] <= tag_last_r[RD_LAT];
        wr_ptr_r <= (wr_ptr_r == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_r + PTR_W'(1);
      end
      fifo_cnt_r  <= cnt_nxt_s;
      out_valid_r <= (cnt_nxt_s != CNT_W'(0));
    end
  end

`ifdef DRAIN_RELU_EN
  function automatic logic [WORD_W-1:0] relu_word(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
    for (int i = 0; i < WORD_W / RES_W; i++) begin
      if (w[i*RES_W + RES_W - 1]) begin
        r[i*RES_W +: RES_W] = '0;
      end else begin
        r[i*RES_W +: RES_W] = w[i*RES_W +: RES_W];
      end
    end
    return r;
  endfunction

  assign out_data = relu_word(fifo_data_r[rd_ptr_r]);
`else
  assign out_data = fifo_data_r[rd_ptr_r];
`endif

  assign out_last     = out_valid_r & fifo_last_r[rd_ptr_r];
  assign out_valid    = out_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign rd_sel       = rd_sel_r;
  assign abuf_rd_addr = addr_r;

endmodule

// File: tb/tb_abuf_drain.sv
// Directed bench for abuf_drain: a table of drain jobs checked against a scoreboard,
// plus hand sequences for reset state and asynchronous reset mid-drain.
module tb_abuf_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   grp_cnt;
  logic [7:0]   addr_cnt;
  logic         busy;
  logic         done;
  logic [2:0]   rd_sel;
  logic [7:0]   abuf_rd_addr;
  logic [127:0] abuf_rd_data;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  int chk_cnt = 0;
  int err_cnt = 0;

  abuf_drain dut (
    .clk(clk), .rst(rst), .start(start), .grp_cnt(grp_cnt), .addr_cnt(addr_cnt),
    .busy(busy), .done(done), .rd_sel(rd_sel), .abuf_rd_addr(abuf_rd_addr),
    .abuf_rd_data(abuf_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Word stored at (group g, address a); lane 3 is negative for odd addresses.
  function automatic logic [127:0] word_of(input int g, input int a);
    logic [127:0] w;
    logic [7:0]   hi;
    for (int i = 0; i < 4; i++) begin
      hi = ((i == 3) && a[0]) ? 8'hF0 : (8'h10 + 8'(i));
      w[i*32 +: 32] = {hi, 8'(g), 8'(a), 8'hA5};
`ifdef DRAIN_RELU_EN
      if (hi[7]) w[i*32 +: 32] = 32'h0;
`endif
    end
    return w;
  endfunction

  function automatic logic [127:0] raw_word(input int g, input int a);
    logic [127:0] w;
    logic [7:0]   hi;
    for (int i = 0; i < 4; i++) begin
      hi = ((i == 3) && a[0]) ? 8'hF0 : (8'h10 + 8'(i));
      w[i*32 +: 32] = {hi, 8'(g), 8'(a), 8'hA5};
    end
    return w;
  endfunction

  // pe_array read port model: RD_LAT = 2 register stages.
  logic [127:0] pe_s1, pe_s2;
  always @(posedge clk) begin
    pe_s1 <= raw_word(int'(rd_sel), int'(abuf_rd_addr));
    pe_s2 <= pe_s1;
  end
  assign abuf_rd_data = pe_s2;

  // Output monitor, sampled on the falling edge.
  logic [128:0] got_q[$];
  int           hs_cyc_q[$];
  int           cyc = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           ovf_cnt = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) begin
      got_q.push_back({out_last, out_data});
      hs_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (int'(dut.fifo_cnt_r) > 4) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] grp;
    logic [7:0] addr;
    int         mode;     // 0 ready high, 1 ready 30% random, 2 ready low for 50 cycles
    bit         restart;  // pulse a conflicting start while busy
    int         n_words;
  } vec_t;

  task automatic run_drain(input vec_t v);
    logic [128:0] exp_q[$];
    int base_w, base_d, base_o, cyc_rel, first_v, n_got, last_i;
    bit done_seen, held_bad;
    logic [127:0] held_data;
    logic [7:0]   held_addr;
    for (int g = 0; g < int'(v.grp); g++)
      for (int a = 0; a <= int'(v.addr); a++)
        exp_q.push_back({(g == int'(v.grp) - 1) && (a == int'(v.addr)), word_of(g, a)});
    base_w = got_q.size(); base_d = done_cnt; base_o = ovf_cnt;
    held_bad = 1'b0; held_data = '0; held_addr = '0;
    out_ready = (v.mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b1;
    start = 1'b1; grp_cnt = v.grp; addr_cnt = v.addr;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 1'b0; cyc_rel = 0; first_v = -1;
    while (!done_seen && cyc_rel < 20000) begin
      if (done) done_seen = 1'b1;
      if (out_valid && first_v < 0) first_v = cyc_rel;
      case (v.mode)
        1: out_ready = ($urandom_range(0, 9) < 3);
        2: out_ready = !(cyc_rel >= 10 && cyc_rel < 60);
        default: out_ready = 1'b1;
      endcase
      if (v.mode == 2 && cyc_rel == 20) begin
        held_data = out_data; held_addr = abuf_rd_addr;
      end else if (v.mode == 2 && cyc_rel > 20 && cyc_rel < 60) begin
        if (out_data !== held_data || abuf_rd_addr !== held_addr || !out_valid) held_bad = 1'b1;
      end
      if (v.restart && cyc_rel == 3) begin
        start = 1'b1; grp_cnt = 4'd8; addr_cnt = 8'd255;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc_rel++;
    end
    if (!done_seen) begin
      chk_cnt++; err_cnt++;
      $display("FAIL timeout: got no done within %0d cycles expected done", cyc_rel);
    end
    check("busy_after_done", busy, 1'b0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt - base_d, 1);
    n_got = got_q.size() - base_w;
    check("word_count", n_got, v.n_words);
    for (int i = 0; i < n_got && i < exp_q.size(); i++)
      check("word", got_q[base_w + i], exp_q[i]);
    check("fifo_bound", ovf_cnt - base_o, 0);
    if (v.n_words == 0) begin
      check("no_valid", first_v, -1);
    end else begin
      check("first_valid_lat", first_v, 3);
    end
    if (v.mode == 0 && n_got > 0) begin
      last_i = hs_cyc_q.size() - 1;
      check("no_bubble", hs_cyc_q[last_i] - hs_cyc_q[base_w], v.n_words - 1);
      check("done_lat", done_cyc - hs_cyc_q[last_i], 1);
    end
    if (v.mode == 2) check("stall_hold", held_bad, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_last"}, out_last, 1'b0);
    check({tag, "_sel"}, rd_sel, 3'd0);
    check({tag, "_addr"}, abuf_rd_addr, 8'd0);
    check({tag, "_data"}, out_data, 128'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{grp: 4'd1, addr: 8'd3,   mode: 0, restart: 1'b0, n_words: 4};
    vecs[1] = '{grp: 4'd8, addr: 8'd255, mode: 0, restart: 1'b0, n_words: 2048};
    vecs[2] = '{grp: 4'd2, addr: 8'd7,   mode: 1, restart: 1'b1, n_words: 16};
    vecs[3] = '{grp: 4'd3, addr: 8'd15,  mode: 2, restart: 1'b0, n_words: 48};
    vecs[4] = '{grp: 4'd8, addr: 8'd0,   mode: 0, restart: 1'b0, n_words: 8};
    vecs[5] = '{grp: 4'd1, addr: 8'd0,   mode: 1, restart: 1'b0, n_words: 1};
    vecs[6] = '{grp: 4'd0, addr: 8'd5,   mode: 0, restart: 1'b1, n_words: 0};

    rst = 1'b1; start = 1'b0; grp_cnt = 4'd0; addr_cnt = 8'd0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #21 check_outputs_zero("reset");
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("post_reset");

    for (int k = 0; k < 7; k++) run_drain(vecs[k]);

    // Asynchronous reset in the middle of a drain, away from the clock edge.
    out_ready = 1'b1; start = 1'b1; grp_cnt = 4'd2; addr_cnt = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_outputs_zero("async_reset");
    #2 rst = 1'b1;
    @(posedge clk); #1;
    run_drain(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
    $finish;
  end

endmodule
